// File: rtl/bdl_status_wb.sv
// Descriptor write-back engine: copies flag/status words from the BDL register
// file to the host descriptor using single-word DMA writes, with an ack timeout.
module bdl_status_wb #(
  parameter int AW  = 22,
  parameter int TMO = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] desc_addr,
  output logic [1:0]    bdl_ra,
  input  logic [15:0]   bdl_rq,
  output logic          dma_req,
  output logic [AW-1:0] dma_addr,
  output logic [15:0]   dma_dout,
  input  logic          dma_ack,
  output logic          busy,
  output logic          done,
  output logic          nxm
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, REQ = 2'd2, FIN = 2'd3} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TMO - 1);

  state_t        state_r, state_s;
  logic          ptr_r, ptr_s;
  logic          mode_r, mode_sel_s;
  logic          timeout_s;
  logic [1:0]    idx_s;
  logic [AW-1:0] base_r;
  logic [15:0]   cnt_r;

  // Byte offset of a descriptor word, keyed by its register-file index.
  function automatic logic [3:0] word_off(input logic [1:0] idx);
    case (idx)
      2'd3:    word_off = 4'd10;
      2'd2:    word_off = 4'd8;
      default: word_off = 4'd0;
    endcase
  endfunction

  // Status 2 (idx 3) is always written before status 1 (idx 2).
  function automatic logic [1:0] word_idx(input logic m, input logic p);
    if (!m) begin
      word_idx = 2'd0;
    end else if (!p) begin
      word_idx = 2'd3;
    end else begin
      word_idx = 2'd2;
    end
  endfunction

  // Next-state logic; an ack in the timeout cycle takes priority over expiry.
  always_comb begin
    state_s   = state_r;
    ptr_s     = ptr_r;
    timeout_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = LOAD;
          ptr_s   = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: state_s = REQ;
      REQ: begin
        if (dma_ack) begin
          if (mode_r && !ptr_r) begin
            state_s = LOAD;
            ptr_s   = 1'b1;
          end else begin
            state_s = FIN;
          end
        end else if (cnt_r == TMO_LAST) begin
          state_s   = FIN;
          timeout_s = 1'b1;
        end else begin
          state_s = REQ;
        end
      end
      FIN:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
    mode_sel_s = (state_r == IDLE) ? mode : mode_r;
    idx_s      = word_idx(mode_sel_s, ptr_s);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      ptr_r    <= 1'b0;
      mode_r   <= 1'b0;
      base_r   <= '0;
      cnt_r    <= 16'd0;
      bdl_ra   <= 2'd0;
      dma_req  <= 1'b0;
      dma_addr <= '0;
      dma_dout <= 16'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      nxm      <= 1'b0;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      if (state_r == IDLE && start) begin
        base_r <= {desc_addr[AW-1:1], 1'b0};
        mode_r <= mode;
        nxm    <= 1'b0;
      end else if (timeout_s) begin
        nxm <= 1'b1;
      end
      // bdl_ra must be valid throughout LOAD, so it is set on entry.
      if (state_s == LOAD) begin
        bdl_ra <= idx_s;
      end else if (state_s == IDLE) begin
        bdl_ra <= 2'd0;
      end else begin
        bdl_ra <= bdl_ra;
      end
      if (state_r == LOAD) begin
        dma_dout <= bdl_rq;
        dma_addr <= base_r + {{(AW-4){1'b0}}, word_off(bdl_ra)};
        cnt_r    <= 16'd0;
      end else if (state_r == REQ) begin
        cnt_r <= cnt_r + 16'd1;
      end else begin
        cnt_r <= cnt_r;
      end
      dma_req <= (state_s == REQ);
      busy    <= (state_s != IDLE);
      done    <= (state_r == FIN);
    end
  end

endmodule
